// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: 16-bit binary to 4-digit BCD converter (double-dabble, one bit per cycle)
// with a free-running scan-tick divider. Define SEG_DISPLAY_OVF_SAT_EN to saturate overflowed values to 9999.
`default_nettype none

module seg_display_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_value,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  units,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands,
    output logic        ovf,
    output logic        conv_done,
    output logic        scan_tick
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int                 CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t            state_q, state_d;
    logic [15:0]       shift_q, shift_d;
    logic [19:0]       bcd_q, bcd_d;
    logic [3:0]        iter_q, iter_d;
    logic [15:0]       digits_q, digits_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [18:0]       bcd_adj;
    logic              handshake;
    logic              bcd_ovf;

    // Gated by rst so in_ready is low during reset yet high immediately after release.
    assign in_ready  = (state_q == ST_IDLE) && rst;
    assign handshake = in_valid && in_ready;
    assign bcd_ovf   = |bcd_q[19:16];

    // The ten-thousands nibble never reaches 5 before the final shift, so it needs no add-3.
    always_comb begin
        bcd_adj = bcd_q[18:0];
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        iter_d   = iter_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    shift_d = in_value;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q, 1'b0};
                iter_d           = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ovf_d   = bcd_ovf;
`ifdef SEG_DISPLAY_OVF_SAT_EN
                digits_d = bcd_ovf ? 16'h9999 : bcd_q[15:0];
`else
                digits_d = bcd_q[15:0];
`endif
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            iter_q   <= iter_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    assign scan_tick = (cnt_q == CNT_LAST);

    assign thousands = digits_q[15:12];
    assign hundreds  = digits_q[11:8];
    assign tens      = digits_q[7:4];
    assign units     = digits_q[3:0];
    assign ovf       = ovf_q;
    assign conv_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: expected commits are queued at each handshake and
// matched against every conv_done pulse, together with latency, ready and scan-tick timing.
`default_nettype none

module tb_seg_display_ctrl;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_value = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  units, tens, hundreds, thousands;
    logic        ovf, conv_done, scan_tick;

    typedef struct {
        logic [16:0] d;
        int          hs;
    } exp_t;

    typedef struct {
        logic [16:0] d;
        int          cyc;
    } obs_t;

    exp_t sb[$];
    obs_t obs[$];
    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;

    seg_display_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_value  (in_value),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .units     (units),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .ovf       (ovf),
        .conv_done (conv_done),
        .scan_tick (scan_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        if (conv_done === 1'b1) begin
            obs.push_back('{d: {thousands, hundreds, tens, units, ovf}, cyc: cyc});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    function automatic logic [16:0] model(input int v);
        int m;
        logic o;
        o = (v > 9999);
        m = v % 10000;
`ifdef SEG_DISPLAY_OVF_SAT_EN
        if (o) m = 9999;
`endif
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10), o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int v, output int hs, output bit ok);
        in_value = 16'(v);
        in_valid = 1'b1;
        ok = 1'b0;
        hs = 0;
        for (int i = 0; i < 60; i++) begin
            if (in_ready === 1'b1) begin
                tick();
                hs = cyc;
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (ok) sb.push_back('{d: model(v), hs: hs});
    endtask

    task automatic get_obs(output obs_t o, output bit ok);
        ok = 1'b0;
        o  = '{d: '0, cyc: 0};
        for (int i = 0; i < 60; i++) begin
            if (obs.size() > 0) begin
                o  = obs.pop_front();
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        tick();
        tick();
        total++; if (in_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", in_ready); else passed++;
        total++; if (scan_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", scan_tick); else passed++;
        total++; if (conv_done !== 1'b0) $display("FAIL reset_done: got %b want 0", conv_done); else passed++;
        total++; if ({thousands, hundreds, tens, units, ovf} !== 17'h0)
            $display("FAIL reset_digits: got %h want 0", {thousands, hundreds, tens, units, ovf}); else passed++;
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_scan_tick();
        int   hs;
        bit   ok;
        obs_t o;
        exp_t e;
        tick();
        rst = 1'b0;
        tick();
        total++; if (scan_tick !== 1'b0) $display("FAIL scan_in_reset: got %b want 0", scan_tick); else passed++;
        rst = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            tick();
            total++;
            if (scan_tick !== ((k % DIV) == DIV - 1))
                $display("FAIL scan_tick_k%0d: got %b want %b", k, scan_tick, ((k % DIV) == DIV - 1));
            else passed++;
            if (k == 12) begin
                in_value = 16'd1234;
                in_valid = 1'b1;
            end else if (k == 13) begin
                in_valid = 1'b0;
                hs = cyc;
                sb.push_back('{d: model(1234), hs: hs});
            end
        end
        get_obs(o, ok);
        total++;
        if (!ok || sb.size() == 0) begin
            $display("FAIL scan_conv_timeout: got no commit want one");
            return;
        end
        passed++;
        e = sb.pop_front();
        total++; if (o.d !== e.d) $display("FAIL scan_conv_digits: got %h want %h", o.d, e.d); else passed++;
    endtask

    task automatic test_basic();
        int   hs;
        bit   ok;
        obs_t o;
        exp_t e;
        send(1234, hs, ok);
        get_obs(o, ok);
        total++;
        if (!ok || sb.size() == 0) begin
            $display("FAIL basic_timeout: got no commit want one");
            return;
        end
        passed++;
        e = sb.pop_front();
        total++; if (o.d !== e.d) $display("FAIL basic_digits: got %h want %h", o.d, e.d); else passed++;
        total++; if (o.d !== 17'h02468) $display("FAIL basic_literal: got %h want 02468", o.d); else passed++;
        total++; if (o.cyc - e.hs !== 17) $display("FAIL basic_latency: got %0d want 17", o.cyc - e.hs); else passed++;
    endtask

    task automatic test_back_to_back();
        int   hs1, hs2;
        bit   ok1, ok2, ok;
        obs_t o;
        exp_t e;
        send(0, hs1, ok1);
        send(9999, hs2, ok2);
        total++; if (!(ok1 && ok2)) $display("FAIL b2b_handshake: got %b%b want 11", ok1, ok2); else passed++;
        total++; if (hs2 - hs1 !== 18) $display("FAIL b2b_spacing: got %0d want 18", hs2 - hs1); else passed++;
        for (int n = 0; n < 2; n++) begin
            get_obs(o, ok);
            total++;
            if (!ok || sb.size() == 0) begin
                $display("FAIL b2b_timeout_%0d: got no commit want one", n);
                return;
            end
            passed++;
            e = sb.pop_front();
            total++; if (o.d !== e.d) $display("FAIL b2b_digits_%0d: got %h want %h", n, o.d, e.d); else passed++;
            total++; if (o.cyc - e.hs !== 17) $display("FAIL b2b_latency_%0d: got %0d want 17", n, o.cyc - e.hs); else passed++;
        end
    endtask

    task automatic test_ignore_busy();
        int   hs1, hs2;
        bit   ok;
        obs_t o;
        exp_t e;
        send(42, hs1, ok);
        in_value = 16'd7;
        in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            total++; if (in_ready !== 1'b0) $display("FAIL busy_ready_k%0d: got %b want 0", k, in_ready); else passed++;
            total++; if ({thousands, hundreds, tens, units, ovf} !== model(9999))
                $display("FAIL busy_hold_k%0d: got %h want %h", k, {thousands, hundreds, tens, units, ovf}, model(9999));
            else passed++;
            tick();
        end
        total++; if (in_ready !== 1'b1) $display("FAIL busy_ready_idle: got %b want 1", in_ready); else passed++;
        tick();
        hs2 = cyc;
        in_valid = 1'b0;
        sb.push_back('{d: model(7), hs: hs2});
        total++; if (hs2 - hs1 !== 18) $display("FAIL busy_accept_spacing: got %0d want 18", hs2 - hs1); else passed++;
        for (int n = 0; n < 2; n++) begin
            get_obs(o, ok);
            total++;
            if (!ok || sb.size() == 0) begin
                $display("FAIL busy_timeout_%0d: got no commit want one", n);
                return;
            end
            passed++;
            e = sb.pop_front();
            total++; if (o.d !== e.d) $display("FAIL busy_digits_%0d: got %h want %h", n, o.d, e.d); else passed++;
            total++; if (o.cyc - e.hs !== 17) $display("FAIL busy_latency_%0d: got %0d want 17", n, o.cyc - e.hs); else passed++;
        end
    endtask

    task automatic test_overflow();
        int   vals[3] = '{12345, 10000, 65535};
        int   hs;
        bit   ok;
        obs_t o;
        exp_t e;
        foreach (vals[i]) begin
            send(vals[i], hs, ok);
            get_obs(o, ok);
            total++;
            if (!ok || sb.size() == 0) begin
                $display("FAIL ovf_timeout_%0d: got no commit want one", vals[i]);
                return;
            end
            passed++;
            e = sb.pop_front();
            total++; if (o.d !== e.d) $display("FAIL ovf_digits_%0d: got %h want %h", vals[i], o.d, e.d); else passed++;
            total++; if (o.d[0] !== 1'b1) $display("FAIL ovf_flag_%0d: got %b want 1", vals[i], o.d[0]); else passed++;
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        in_value = 16'd5678;
        in_valid = 1'b1;
        total++; if (in_ready !== 1'b1) $display("FAIL abort_ready_before: got %b want 1", in_ready); else passed++;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b0;
        #1;
        total++; if ({thousands, hundreds, tens, units, ovf} !== 17'h0)
            $display("FAIL abort_digits_reset: got %h want 0", {thousands, hundreds, tens, units, ovf}); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL abort_ready_reset: got %b want 0", in_ready); else passed++;
        tick();
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL abort_ready_release: got %b want 1", in_ready); else passed++;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (conv_done !== 1'b0) seen++;
        end
        total++; if (seen !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", seen); else passed++;
        total++; if ({thousands, hundreds, tens, units, ovf} !== 17'h0)
            $display("FAIL abort_digits_after: got %h want 0", {thousands, hundreds, tens, units, ovf}); else passed++;
    endtask

    initial begin
        test_reset();
        test_scan_tick();
        test_basic();
        test_back_to_back();
        test_ignore_busy();
        test_overflow();
        test_reset_abort();
        total++; if (obs.size() !== 0) $display("FAIL leftover_commits: got %0d want 0", obs.size()); else passed++;
        total++; if (sb.size() !== 0) $display("FAIL leftover_expected: got %0d want 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000; scan-tick period in clk cycles, legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_value, input, 16, unsigned binary value to display.
REQ-005 SHALL have port in_valid, input, 1, in_value is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, controller accepts a value this cycle.
REQ-007 SHALL have ports units, tens, hundreds, thousands, output, 4 each, committed BCD digits for the scan stage.
REQ-008 SHALL have port ovf, output, 1, committed value exceeded 9999.
REQ-009 SHALL have port conv_done, output, 1, one-cycle pulse when new digits commit.
REQ-010 SHALL have port scan_tick, output, 1, one-cycle pulse every REFRESH_DIV cycles, clock enable for the digit scan.

Function
REQ-011 SHALL implement FSM IDLE -> CONV -> DONE -> IDLE.
REQ-012 SHALL assert in_ready only in IDLE; handshake occurs on an edge where in_valid and in_ready are both high.
REQ-013 SHALL, on handshake, load in_value into a 16-bit shift register, clear a 20-bit BCD accumulator and a 4-bit iteration counter, and enter CONV.
REQ-014 SHALL, in CONV, perform one double-dabble iteration per cycle: add 3 to each BCD nibble >= 5, then shift {BCD, shift register} left by one.
REQ-015 SHALL leave CONV for DONE on the edge that completes iteration 16, i.e. 16 edges after the handshake.
REQ-016 SHALL, in DONE, update units..thousands and ovf, pulse conv_done for exactly one cycle, and return to IDLE, i.e. 17 edges after the handshake.
REQ-017 SHALL set ovf=1 when in_value > 9999, otherwise ovf=0.
REQ-018 SHALL hold units..thousands and ovf stable at all times except the DONE commit edge.
REQ-019 SHALL ignore in_valid while in CONV or DONE; such values are dropped and no queueing is done.
REQ-020 SHALL accept a new value on the first cycle after DONE, giving a back-to-back throughput of one value per 18 cycles.
REQ-021 SHALL free-run the refresh counter from 0 to REFRESH_DIV-1 and wrap to 0, independent of the FSM.
REQ-022 SHALL assert scan_tick in the cycle the counter equals REFRESH_DIV-1.

Reset
REQ-023 SHALL, while rst=0, force state IDLE, all digits 0, ovf=0, conv_done=0, scan_tick=0, refresh counter 0, and in_ready=0.
REQ-024 SHALL assert in_ready in the first cycle after rst deasserts.
REQ-025 SHALL, on reset during CONV or DONE, abort the conversion and commit no digits.

Configuration
REQ-026 SHALL provide macro SEG_DISPLAY_OVF_SAT_EN.
REQ-027 SHALL, with SEG_DISPLAY_OVF_SAT_EN defined and ovf=1, commit digits 9,9,9,9.
REQ-028 SHALL, without SEG_DISPLAY_OVF_SAT_EN, commit the low four BCD digits, i.e. in_value mod 10000, when ovf=1.
REQ-029 SHALL compute and output ovf identically in both builds.

Verification
REQ-030 SHALL cover: in_value=1234 handshake at edge N -> conv_done high after edge N+17; thousands..units=1,2,3,4; ovf=0.
REQ-031 SHALL cover: in_value=0, then in_value=9999 back-to-back -> digits 0,0,0,0, then 9,9,9,9; second handshake exactly 18 cycles after first.
REQ-032 SHALL cover: in_value=12345 -> ovf=1; digits 9,9,9,9 with SEG_DISPLAY_OVF_SAT_EN, and 2,3,4,5 without it.
REQ-033 SHALL cover: in_valid held high with value 7 during CONV of 42 -> in_ready=0 throughout; committed digits 0,0,4,2; value 7 accepted only after return to IDLE.
REQ-034 SHALL cover: rst low at iteration 8 of converting 5678 -> digits stay 0,0,0,0; no conv_done; in_ready high on the first cycle after release.
REQ-035 SHALL cover: REFRESH_DIV=4 -> scan_tick high every 4th cycle, first at cycle 3 after reset release; period unaffected by conversions.
